// File: rtl/reflection_lookup_arbiter.sv
// Round-robin arbiter sharing one name-to-handle lookup engine among NUM_REQ
// requesters, with a single outstanding lookup, timeout and stale-response discard.
module reflection_lookup_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned HANDLE_W = 32,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [HANDLE_W-1:0]        rsp_handle,
    output logic                       rsp_hit,
    output logic                       rsp_timeout,
    output logic                       lk_valid,
    input  logic                       lk_ready,
    output logic [KEY_W-1:0]           lk_key,
    input  logic                       lk_rsp_valid,
    input  logic                       lk_rsp_hit,
    input  logic [HANDLE_W-1:0]        lk_rsp_handle,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TMW = 16;
    localparam int unsigned SW  = 2;
    localparam logic [SW-1:0]  STALE_MAX = SW'(3);
    localparam logic [TMW-1:0] TMO_LAST  = TMW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [SW-1:0]         stale_q, stale_d;
    logic [TMW-1:0]        timer_q, timer_d;
    logic [KEY_W-1:0]      key_q, key_d;
    logic                  lk_valid_q, lk_valid_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [HANDLE_W-1:0]   handle_q, handle_d;
    logic                  hit_q, hit_d;
    logic                  tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]    req_ready_c;

    logic                  arb_found_c;
    logic [IDW-1:0]        arb_idx_c;
    logic                  stale_dec_c;
    logic                  stale_inc_c;
    logic [KEY_W-1:0]      keys_c [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_key
        assign keys_c[g] = req_key[g*KEY_W +: KEY_W];
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin : arb_scan
        int unsigned idx;
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!arb_found_c && req_valid[IDW'(idx)]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = IDW'(idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        stale_d     = stale_q;
        timer_d     = timer_q;
        key_d       = key_q;
        handle_d    = handle_q;
        hit_d       = hit_q;
        tmo_d       = tmo_q;
        req_ready_c = '0;
        stale_inc_c = 1'b0;
        // Any response arriving while stale lookups are owed is the oldest one: drop it.
        stale_dec_c = lk_rsp_valid && (stale_q != '0);

        case (state_q)
            S_IDLE: begin
                if (arb_found_c && (stale_q != STALE_MAX)) begin
                    req_ready_c[arb_idx_c] = 1'b1;
                    grant_d = arb_idx_c;
                    key_d   = keys_c[arb_idx_c];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lk_ready) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMW'(1);
                if (lk_rsp_valid && (stale_q == '0)) begin
                    handle_d = lk_rsp_handle;
                    hit_d    = lk_rsp_hit;
                    tmo_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (timer_q == TMO_LAST) begin
                    handle_d    = '0;
                    hit_d       = 1'b0;
                    tmo_d       = 1'b1;
                    stale_inc_c = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[grant_q]) begin
                    ptr_d   = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stale_inc_c && !stale_dec_c) begin
            stale_d = (stale_q == STALE_MAX) ? STALE_MAX : stale_q + SW'(1);
        end else if (stale_dec_c && !stale_inc_c) begin
            stale_d = stale_q - SW'(1);
        end

        lk_valid_d  = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        grant_id_d  = (state_d == S_IDLE) ? '0 : grant_d;
        rsp_valid_d = (state_d == S_RESP) ? (NUM_REQ'(1) << grant_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            stale_q     <= '0;
            timer_q     <= '0;
            key_q       <= '0;
            lk_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            handle_q    <= '0;
            hit_q       <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            stale_q     <= stale_d;
            timer_q     <= timer_d;
            key_q       <= key_d;
            lk_valid_q  <= lk_valid_d;
            rsp_valid_q <= rsp_valid_d;
            handle_q    <= handle_d;
            hit_q       <= hit_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
        end
    end

    // The accept strobe is combinational, so it is forced low while reset is held.
    assign req_ready   = req_ready_c & {NUM_REQ{rst_n}};
    assign lk_valid    = lk_valid_q;
    assign lk_key      = key_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_handle  = handle_q;
    assign rsp_hit     = hit_q;
    assign rsp_timeout = tmo_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_reflection_lookup_arbiter.sv
// Directed self-checking bench for reflection_lookup_arbiter (4 requesters, TIMEOUT=10).
module tb_reflection_lookup_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_key;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_handle;
    logic         rsp_hit;
    logic         rsp_timeout;
    logic         lk_valid;
    logic         lk_ready;
    logic [31:0]  lk_key;
    logic         lk_rsp_valid;
    logic         lk_rsp_hit;
    logic [31:0]  lk_rsp_handle;
    logic         busy;
    logic [1:0]   grant_id;

    int checks;
    int failures;

    reflection_lookup_arbiter #(
        .NUM_REQ (4),
        .KEY_W   (32),
        .HANDLE_W(32),
        .TIMEOUT (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_handle   (rsp_handle),
        .rsp_hit      (rsp_hit),
        .rsp_timeout  (rsp_timeout),
        .lk_valid     (lk_valid),
        .lk_ready     (lk_ready),
        .lk_key       (lk_key),
        .lk_rsp_valid (lk_rsp_valid),
        .lk_rsp_hit   (lk_rsp_hit),
        .lk_rsp_handle(lk_rsp_handle),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Plays requester and engine for one transaction; starts and ends at a negedge.
    // lat = negedges from the lk handshake negedge until rsp_valid is seen.
    task automatic drive_txn(input logic drop, input int n_late, input logic respond,
                             input logic rhit, input logic [31:0] handle,
                             output logic [3:0] g, output logic [31:0] key,
                             output logic [3:0] rv, output logic [31:0] h,
                             output logic hit, output logic to, output int lat);
        int n;
        g = '0; key = '1; rv = '0; h = '0; hit = 1'b0; to = 1'b0; lat = -1;
        n = 0;
        #1;
        while (req_ready == 4'h0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        g = req_ready;
        if (g == 4'h0) return;
        @(negedge clk);
        if (drop) req_valid = req_valid & ~g;
        key = lk_valid ? lk_key : 32'hFFFF_FFFF;
        lk_ready = 1'b1;
        @(negedge clk);
        lk_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid != 4'h0) begin
                lat = k;
                break;
            end
            if (k <= n_late) begin
                lk_rsp_valid = 1'b1; lk_rsp_hit = 1'b1; lk_rsp_handle = 32'hDEAD_0000 + 32'(k);
            end else if (respond && k == n_late + 1) begin
                lk_rsp_valid = 1'b1; lk_rsp_hit = rhit; lk_rsp_handle = handle;
            end else begin
                lk_rsp_valid = 1'b0;
            end
            @(negedge clk);
        end
        lk_rsp_valid = 1'b0;
        rv = rsp_valid; h = rsp_handle; hit = rsp_hit; to = rsp_timeout;
        if (rv == 4'h0) return;
        rsp_ready = rv;
        @(negedge clk);
        rsp_ready = 4'h0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++; $display("FAIL reset_req_ready: got %h expected 0", req_ready);
        end
        checks++;
        if ({lk_valid, rsp_valid, rsp_hit, rsp_timeout, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {lk_valid, rsp_valid, rsp_hit, rsp_timeout, busy});
        end
        checks++;
        if (lk_key !== 32'h0 || rsp_handle !== 32'h0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_buses: got key=%h handle=%h gid=%0d expected 0", lk_key, rsp_handle, grant_id);
        end
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] g, rv; logic [31:0] key, h; logic hit, to; int lat;
        for (int i = 0; i < 4; i++) req_key[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            drive_txn(1'b0, 0, 1'b1, n[0], 32'h100 + 32'(n), g, key, rv, h, hit, to, lat);
            if (n == 7) req_valid = 4'h0;
            checks++;
            if (g !== 4'(1 << (n % 4))) begin
                failures++; $display("FAIL fair_grant[%0d]: got %b expected %b", n, g, 4'(1 << (n % 4)));
            end
            checks++;
            if (key !== 32'hA000_0000 + 32'(n % 4)) begin
                failures++; $display("FAIL fair_key[%0d]: got %h expected %h", n, key, 32'hA000_0000 + 32'(n % 4));
            end
            checks++;
            if (rv !== 4'(1 << (n % 4)) || h !== 32'h100 + 32'(n) || hit !== n[0] || to !== 1'b0) begin
                failures++;
                $display("FAIL fair_rsp[%0d]: got rv=%b h=%h hit=%b to=%b expected rv=%b h=%h hit=%b to=0",
                         n, rv, h, hit, to, 4'(1 << (n % 4)), 32'h100 + 32'(n), n[0]);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] g, rv; logic [31:0] key, h; logic hit, to; int lat;
        req_key[2*32 +: 32] = 32'hCAFE_0001;
        req_valid = 4'b0100;
        drive_txn(1'b1, 0, 1'b1, 1'b1, 32'h1234, g, key, rv, h, hit, to, lat);
        checks++;
        if (g !== 4'b0100) begin
            failures++; $display("FAIL single_grant: got %b expected 0100", g);
        end
        checks++;
        if (key !== 32'hCAFE_0001) begin
            failures++; $display("FAIL single_lk_key: got %h expected cafe0001", key);
        end
        checks++;
        if (rv !== 4'b0100 || h !== 32'h1234 || hit !== 1'b1 || to !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL single_rsp: got rv=%b h=%h hit=%b to=%b lat=%0d expected rv=0100 h=1234 hit=1 to=0 lat=2",
                     rv, h, hit, to, lat);
        end
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || rsp_valid !== 4'h0) begin
            failures++; $display("FAIL single_idle: got busy=%b gid=%0d rv=%b expected 0/0/0", busy, grant_id, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] g, rv; logic [31:0] key, h; logic hit, to; int lat;
        req_key[0 +: 32] = 32'h0000_0AAA;
        req_valid = 4'b0001;
        drive_txn(1'b1, 0, 1'b0, 1'b0, 32'h0, g, key, rv, h, hit, to, lat);
        checks++;
        if (g !== 4'b0001 || rv !== 4'b0001 || to !== 1'b1 || hit !== 1'b0 || h !== 32'h0 || lat !== 11) begin
            failures++;
            $display("FAIL timeout_rsp: got g=%b rv=%b to=%b hit=%b h=%h lat=%0d expected 0001/0001/1/0/0/11",
                     g, rv, to, hit, h, lat);
        end
        req_key[32 +: 32] = 32'h0000_0BBB;
        req_valid = 4'b0010;
        drive_txn(1'b1, 1, 1'b1, 1'b1, 32'hBEEF, g, key, rv, h, hit, to, lat);
        checks++;
        if (g !== 4'b0010 || rv !== 4'b0010 || h !== 32'hBEEF || hit !== 1'b1 || to !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL late_drop: got g=%b rv=%b h=%h hit=%b to=%b lat=%0d expected 0010/0010/beef/1/0/3",
                     g, rv, h, hit, to, lat);
        end
    endtask

    task automatic test_stale_saturation();
        logic [3:0] g, rv; logic [31:0] key, h; logic hit, to; int lat;
        logic [3:0] order [3];
        order[0] = 4'b0100; order[1] = 4'b1000; order[2] = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            req_valid = order[n];
            drive_txn(1'b1, 0, 1'b0, 1'b0, 32'h0, g, key, rv, h, hit, to, lat);
            checks++;
            if (g !== order[n] || to !== 1'b1 || lat !== 11) begin
                failures++;
                $display("FAIL stale_tmo[%0d]: got g=%b to=%b lat=%0d expected %b/1/11", n, g, to, lat, order[n]);
            end
        end
        req_key[32 +: 32] = 32'h0000_0C0C;
        req_valid = 4'b0010;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (req_ready !== 4'h0 || busy !== 1'b0) begin
                failures++; $display("FAIL stale_block[%0d]: got ready=%b busy=%b expected 0000/0", n, req_ready, busy);
            end
            @(negedge clk);
        end
        req_valid = 4'h0;
        for (int n = 0; n < 2; n++) begin
            lk_rsp_valid = 1'b1; lk_rsp_hit = 1'b1; lk_rsp_handle = 32'hDEAD_00F0 + 32'(n);
            @(negedge clk);
            lk_rsp_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 4'b0010;
        drive_txn(1'b1, 1, 1'b1, 1'b0, 32'h600D, g, key, rv, h, hit, to, lat);
        checks++;
        if (g !== 4'b0010 || h !== 32'h600D || hit !== 1'b0 || to !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL stale_resume: got g=%b h=%h hit=%b to=%b lat=%0d expected 0010/600d/0/0/3", g, h, hit, to, lat);
        end
    endtask

    // Leaves requester 3 being granted so the following reset lands mid-transaction.
    task automatic test_backpressure();
        logic ok;
        req_key[32 +: 32] = 32'h0B0B_0001;
        req_key[96 +: 32] = 32'h0303_0003;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        ok = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (lk_valid !== 1'b1 || lk_key !== 32'h0B0B_0001) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok || lk_valid !== 1'b1 || lk_key !== 32'h0B0B_0001) begin
            failures++; $display("FAIL bp_lk_stable: got lk_valid=%b key=%h expected 1/0b0b0001", lk_valid, lk_key);
        end
        lk_ready = 1'b1;
        @(negedge clk);
        lk_ready = 1'b0;
        lk_rsp_valid = 1'b1; lk_rsp_hit = 1'b0; lk_rsp_handle = 32'h77;
        @(negedge clk);
        lk_rsp_valid = 1'b0;
        req_valid = 4'b1000;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_handle !== 32'h77 || rsp_hit !== 1'b0 || req_ready !== 4'h0) begin
                failures++;
                $display("FAIL bp_rsp_hold[%0d]: got rv=%b h=%h hit=%b ready=%b expected 0010/77/0/0000",
                         n, rsp_valid, rsp_handle, rsp_hit, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = 4'h0;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || rsp_valid !== 4'h0) begin
            failures++; $display("FAIL bp_next_grant: got ready=%b rv=%b expected 1000/0000", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] g, rv; logic [31:0] key, h; logic hit, to; int lat;
        @(negedge clk);
        req_valid = 4'h0;
        lk_ready = 1'b1;
        @(negedge clk);
        lk_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || lk_valid !== 1'b0 || grant_id !== 2'd3) begin
            failures++; $display("FAIL rst_pre_wait: got busy=%b lk_valid=%b gid=%0d expected 1/0/3", busy, lk_valid, grant_id);
        end
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0 || lk_valid !== 1'b0 ||
            rsp_valid !== 4'h0 || lk_key !== 32'h0 || rsp_handle !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_wait: got ready=%b busy=%b gid=%0d lkv=%b rv=%b key=%h h=%h expected all 0",
                     req_ready, busy, grant_id, lk_valid, rsp_valid, lk_key, rsp_handle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_txn(1'b1, 0, 1'b1, 1'b1, 32'h5555, g, key, rv, h, hit, to, lat);
        req_valid = 4'h0;
        checks++;
        if (g !== 4'b0010 || key !== 32'h0B0B_0001) begin
            failures++; $display("FAIL rst_regrant: got g=%b key=%h expected 0010/0b0b0001", g, key);
        end
        checks++;
        if (rv !== 4'b0010 || h !== 32'h5555 || hit !== 1'b1 || to !== 1'b0 || lat !== 2) begin
            failures++;
            $display("FAIL rst_rsp: got rv=%b h=%h hit=%b to=%b lat=%0d expected 0010/5555/1/0/2", rv, h, hit, to, lat);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b1;
        req_valid = 4'h0; req_key = '0; rsp_ready = 4'h0;
        lk_ready = 1'b0; lk_rsp_valid = 1'b0; lk_rsp_hit = 1'b0; lk_rsp_handle = '0;
        test_reset();
        test_fairness();
        test_single();
        test_timeout();
        test_stale_saturation();
        test_backpressure();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reflection_lookup_arbiter.md
Name: reflection_lookup_arbiter

Overview:
- Shares one name-to-handle lookup engine between NUM_REQ requesters. Each requester presents a hashed object-name key and receives back a handle plus hit/timeout status.
- Sits between the requester-side reflection clients and the single lookup/cache datapath.
- Round-robin arbitration, one lookup outstanding at a time, with timeout and stale-response discard.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- KEY_W, 32, lookup key width.
- HANDLE_W, 32, returned handle width.
- TIMEOUT, 255, cycles to wait for a lookup response before abandoning it (1..65535).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit set.
- req_key  in  NUM_REQ*KEY_W  packed keys; requester i occupies bits [i*KEY_W +: KEY_W].
- rsp_valid  out  NUM_REQ  per-requester response valid; at most one bit set.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_handle  out  HANDLE_W  response handle (shared bus).
- rsp_hit  out  1  response hit flag.
- rsp_timeout  out  1  set when the response was generated by timeout.
- lk_valid  out  1  lookup issue valid.
- lk_ready  in  1  lookup engine accepts the key.
- lk_key  out  KEY_W  key to the lookup engine.
- lk_rsp_valid  in  1  lookup result strobe; single cycle, no backpressure.
- lk_rsp_hit  in  1  lookup hit.
- lk_rsp_handle  in  HANDLE_W  lookup handle.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; 0 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, FSM to IDLE, round-robin pointer ptr=0, stale counter=0, timer=0.
  - Reset mid-operation abandons the transaction silently; requesters re-present.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and stale<3, grant the first set index scanning ptr, ptr+1, ... wrapping mod NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; key is latched; next state ISSUE.
  - If stale==3, no grant is made and req_ready stays 0.
- ISSUE:
  - lk_valid=1, lk_key=latched key; both held stable until lk_ready.
  - On lk_valid&&lk_ready: timer cleared, go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If lk_rsp_valid and stale==0: latch hit/handle, timeout=0, go to RESP.
  - If lk_rsp_valid and stale>0: decrement stale, drop the response, stay in WAIT. Responses return in order, so the oldest is the stale one.
  - If the timer reaches TIMEOUT with no accepted response: hit=0, handle=0, timeout=1, stale+1 (saturates at 3), go to RESP.
  - A response and the timeout in the same cycle: the response wins, no timeout.
- RESP:
  - rsp_valid[grant]=1 with latched handle/hit/timeout, held until rsp_ready[grant].
  - On handshake: ptr=(grant+1) mod NUM_REQ, go to IDLE.
- lk_rsp_valid outside WAIT:
  - Decrements stale if nonzero and is otherwise dropped.
  - An unexpected response with stale==0 is ignored.
- Best-case latency, lk_ready and the engine both responding immediately:
  - Accept cycle T; lk_valid at T+1; lk_rsp_valid at T+2; rsp_valid at T+3.
- Key/handle buses outside their valid windows hold their last value.

Test Plan:
- Single request, no contention: req_valid[2]=1, key=0xCAFE0001; engine responds hit, handle=0x1234 one cycle after lk_ready -> req_ready[2] at T, lk_key=0xCAFE0001 at T+1, rsp_valid[2] with handle 0x1234, hit=1 at T+3.
- Fairness: all 4 requesters valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester served twice before another pending one.
- Timeout: engine never responds, TIMEOUT=10 -> rsp_valid with timeout=1, hit=0, handle=0 exactly 10 cycles after lk handshake. The late response then arrives during the next WAIT, gets dropped, and the following genuine response is delivered.
- Stale saturation: 3 consecutive timeouts -> stale=3, req_ready held 0 despite req_valid. Two late responses arrive -> stale=1, grants resume.
- Backpressure: lk_ready low 5 cycles -> lk_valid/lk_key stable. rsp_ready low 4 cycles -> rsp_valid/handle stable, no new grant.
- Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately, ptr=0; the next request from requester 1 is granted normally.
